// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Instruction-granular circular queue between the fetch stage
//                register and decode; splits fetch packets into per-instruction
//                entries and presents up to two in-order entries per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst0,
  input  logic [31:0]   in_inst1,
  input  logic [31:0]   in_badv,
  input  logic [6:0]    in_exception,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic          out_ready,
  output logic          out0_valid,
  output logic          out1_valid,
  output logic [31:0]   out0_pc,
  output logic [31:0]   out1_pc,
  output logic [31:0]   out0_inst,
  output logic [31:0]   out1_inst,
  output logic [6:0]    out0_exception,
  output logic [6:0]    out1_exception,
  output logic [31:0]   out0_badv,
  output logic [31:0]   out1_badv
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] c_nop       = 32'h0340_0000;
  localparam logic [31:0] c_idle_pc   = 32'h1c00_0000;
  localparam logic [CW-1:0] c_ready_max = CW'(DEPTH - 2);
  localparam logic [CW-1:0] c_one       = CW'(1);

  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_inst_mem [DEPTH];
  logic [6:0]  r_exc_mem  [DEPTH];
  logic [31:0] r_badv_mem [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_ready;
  logic          w_push;
  logic          w_push_two;
  logic          w_in_fault;
  logic [1:0]    w_push_n;
  logic          w_pop;
  logic [1:0]    w_pop_n;
  logic          w_v0;
  logic          w_v1;
  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [31:0]   w_ent0_inst;
  logic [31:0]   w_ent0_badv;

  // Readiness depends only on the registered count so a full packet always fits.
  assign w_ready    = (r_count <= c_ready_max);
  assign in_ready   = w_ready;
  assign full       = ~w_ready;
  assign count      = r_count;

  assign w_in_fault = (in_exception != 7'd0);
  assign w_push     = in_valid & w_ready & ~flush;
  assign w_push_two = w_push & ~w_in_fault & ~in_pc[2];
  assign w_push_n   = w_push_two ? 2'd2 : (w_push ? 2'd1 : 2'd0);

  assign w_ent0_inst = w_in_fault ? c_nop : (in_pc[2] ? in_inst1 : in_inst0);
  assign w_ent0_badv = w_in_fault ? in_badv : 32'd0;

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);

  // A faulting entry at the head is always issued alone.
  assign w_v0    = (r_count != '0);
  assign w_v1    = (r_count > c_one) & (r_exc_mem[r_head] == 7'd0);
  assign w_pop   = out_ready & w_v0 & ~flush;
  assign w_pop_n = w_pop ? (w_v1 ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= in_pc;
      r_inst_mem[r_tail] <= w_ent0_inst;
      r_exc_mem[r_tail]  <= in_exception;
      r_badv_mem[r_tail] <= w_ent0_badv;
    end
    if (w_push_two) begin
      r_pc_mem[w_tail1]   <= in_pc + 32'd4;
      r_inst_mem[w_tail1] <= in_inst1;
      r_exc_mem[w_tail1]  <= 7'd0;
      r_badv_mem[w_tail1] <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop_n);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  always_comb begin
    out0_valid     = w_v0;
    out0_pc        = c_idle_pc;
    out0_inst      = c_nop;
    out0_exception = 7'd0;
    out0_badv      = 32'd0;
    if (w_v0) begin
      out0_pc        = r_pc_mem[r_head];
      out0_inst      = r_inst_mem[r_head];
      out0_exception = r_exc_mem[r_head];
      out0_badv      = r_badv_mem[r_head];
    end
  end

  always_comb begin
    out1_valid     = w_v1;
    out1_pc        = c_idle_pc;
    out1_inst      = c_nop;
    out1_exception = 7'd0;
    out1_badv      = 32'd0;
    if (w_v1) begin
      out1_pc        = r_pc_mem[w_head1];
      out1_inst      = r_inst_mem[w_head1];
      out1_exception = r_exc_mem[w_head1];
      out1_badv      = r_badv_mem[w_head1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Scoreboard testbench for fetch_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam logic [31:0] c_nop     = 32'h0340_0000;
  localparam logic [31:0] c_idle_pc = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  exc;
    logic [31:0] badv;
  } ent_t;

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, in_ready, full, out_ready;
  logic [31:0]   in_pc, in_inst0, in_inst1, in_badv;
  logic [6:0]    in_exception;
  logic [CW-1:0] count;
  logic          out0_valid, out1_valid;
  logic [31:0]   out0_pc, out1_pc, out0_inst, out1_inst, out0_badv, out1_badv;
  logic [6:0]    out0_exception, out1_exception;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_badv(in_badv),
    .in_exception(in_exception), .full(full), .count(count),
    .out_ready(out_ready), .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_pc(out0_pc), .out1_pc(out1_pc), .out0_inst(out0_inst),
    .out1_inst(out1_inst), .out0_exception(out0_exception),
    .out1_exception(out1_exception), .out0_badv(out0_badv), .out1_badv(out1_badv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    ent_t e0, e1;
    logic v0, v1;
    v0 = (q.size() >= 1);
    v1 = (q.size() >= 2) && (q[0].exc == 7'd0);
    e0 = '{pc: c_idle_pc, inst: c_nop, exc: 7'd0, badv: 32'd0};
    e1 = e0;
    if (v0) e0 = q[0];
    if (v1) e1 = q[1];
    check("count",    32'(count),    32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() <= DEPTH - 2));
    check("full",     32'(full),     32'(q.size() > DEPTH - 2));
    check("out0_valid", 32'(out0_valid), 32'(v0));
    check("out1_valid", 32'(out1_valid), 32'(v1));
    check("out0_pc",   out0_pc,   e0.pc);
    check("out0_inst", out0_inst, e0.inst);
    check("out0_exc",  32'(out0_exception), 32'(e0.exc));
    check("out0_badv", out0_badv, e0.badv);
    check("out1_pc",   out1_pc,   e1.pc);
    check("out1_inst", out1_inst, e1.inst);
    check("out1_exc",  32'(out1_exception), 32'(e1.exc));
    check("out1_badv", out1_badv, e1.badv);
  endtask

  task automatic push_model();
    if (in_exception != 7'd0)
      q.push_back('{pc: in_pc, inst: c_nop, exc: in_exception, badv: in_badv});
    else if (in_pc[2])
      q.push_back('{pc: in_pc, inst: in_inst1, exc: 7'd0, badv: 32'd0});
    else begin
      q.push_back('{pc: in_pc, inst: in_inst0, exc: 7'd0, badv: 32'd0});
      q.push_back('{pc: in_pc + 32'd4, inst: in_inst1, exc: 7'd0, badv: 32'd0});
    end
  endtask

  // Check at the falling edge, then advance the scoreboard across the rising edge.
  task automatic cycle();
    bit do_push, do_pop;
    int n;
    @(negedge clk);
    compare_outputs();
    do_pop  = out_ready && (q.size() >= 1) && !flush;
    n       = ((q.size() >= 2) && (q[0].exc == 7'd0)) ? 2 : 1;
    do_push = in_valid && (q.size() <= DEPTH - 2) && !flush;
    @(posedge clk);
    if (!rstn || flush) q.delete();
    else begin
      if (do_pop) repeat (n) void'(q.pop_front());
      if (do_push) push_model();
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [6:0] exc,
                       input logic [31:0] badv, input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_inst0 = i0; in_inst1 = i1;
    in_exception = exc; in_badv = badv; out_ready = ordy; flush = fl;
    cycle();
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 32'h0, 7'd0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst0 = '0; in_inst1 = '0; in_badv = '0; in_exception = '0;
    // Reset state, including a packet offered while reset is held.
    drive(1'b1, 32'h1c00_0000, 32'h1111_0000, 32'h2222_0000, 7'd0, 32'h0, 1'b1, 1'b0);
    idle(1'b0, 1);
    rstn = 1'b1;

    // Two-entry packet, decode stalled.
    drive(1'b1, 32'h1c00_0000, 32'hAAAA_0000, 32'hBBBB_0000, 7'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Upper-half packet yields a single entry.
    drive(1'b1, 32'h1c00_0014, 32'hDEAD_0000, 32'hCCCC_0000, 7'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 1);

    // Faulting packet followed by a normal pair.
    drive(1'b1, 32'h1c00_0020, 32'h1234_0000, 32'h5678_0000, 7'h08, 32'h1c00_0020, 1'b0, 1'b0);
    drive(1'b1, 32'h1c00_0028, 32'h9999_0000, 32'h8888_0000, 7'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Fill to 15, hold an unaccepted packet, then pop two.
    for (int i = 0; i < 7; i++)
      drive(1'b1, 32'h1c00_0100 + 32'(i * 8), 32'hF000_0000 + 32'(i), 32'hF100_0000 + 32'(i),
            7'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h1c00_0144, 32'h0, 32'hF200_0000, 7'd0, 32'h0, 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'd15);
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h1c00_0200, 32'hE000_0000, 32'hE100_0000, 7'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1, 1);
    check("after_pop_ready", 32'(in_ready), 32'd1);
    idle(1'b1, 8);

    // Fill to exactly DEPTH, then drain.
    for (int i = 0; i < 9; i++)
      drive(1'b1, 32'h1c00_0300 + 32'(i * 8), 32'hD000_0000 + 32'(i), 32'hD100_0000 + 32'(i),
            7'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b1, 9);

    // Continuous stream across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1c00_1000 + 32'(i * 8), 32'hC000_0000 + 32'(i), 32'hC100_0000 + 32'(i),
            7'd0, 32'h0, 1'b1, 1'b0);
      check("stream_count_le2", 32'(count <= 2), 32'd1);
    end
    idle(1'b1, 2);

    // Flush with count=6 while pushing and popping.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h1c00_2000 + 32'(i * 8), 32'hB000_0000 + 32'(i), 32'hB100_0000 + 32'(i),
            7'd0, 32'h0, 1'b0, 1'b0);
    check("preflush_count", 32'(count), 32'd6);
    drive(1'b1, 32'h1c00_2100, 32'h7, 32'h8, 7'd0, 32'h0, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out0_valid", 32'(out0_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    idle(1'b1, 1);

    // Asynchronous reset mid-operation, away from any clock edge.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 32'h1c00_3000 + 32'(i * 8), 32'hA0, 32'hA1, 7'd0, 32'h0, 1'b0, 1'b0);
    rstn = 1'b0;
    #2;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out0_valid", 32'(out0_valid), 32'd0);
    q.delete();
    rstn = 1'b1;
    idle(1'b0, 1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] exc;
      exc = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      drive(1'($urandom_range(0, 3) != 0),
            32'h1c00_4000 + 32'(i * 8) + ($urandom_range(0, 1) != 0 ? 32'd4 : 32'd0),
            $urandom, $urandom, exc, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    idle(1'b1, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-granular circular queue between the IF1→FIFO stage register and decode. Accepts one fetch packet per cycle (PC, up to two instructions, fetch exception), splits it into per-instruction entries, and presents up to two in-order instructions per cycle to decode. Its `in_ready` is the `fifo_ready` seen by the upstream stage register, and its `full` drives `fetch_buf_full`.

## Interface
- `DEPTH`, default 16: entry count; power of two, ≥4.
- `CW`, default $clog2(DEPTH)+1: width of `count`.

- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous discard of all contents (branch mispredict / exception redirect)
- `in_valid`  in  1  upstream packet valid
- `in_ready`  out  1  buffer can accept a full packet
- `in_pc`  in  32  packet PC, word aligned
- `in_inst0`, `in_inst1`  in  32 each  instructions at `{in_pc[31:3],3'b000}` and `+4`
- `in_badv`  in  32  fault address
- `in_exception`  in  7  fetch exception code; nonzero = faulting packet
- `full`  out  1  equals `~in_ready`
- `count`  out  CW  occupied entries
- `out_ready`  in  1  decode consumes every entry presented this cycle
- `out0_valid`, `out1_valid`  out  1 each  slot valid; `out1_valid` implies `out0_valid`
- `out0_pc`, `out1_pc`  out  32 each
- `out0_inst`, `out1_inst`  out  32 each
- `out0_exception`, `out1_exception`  out  7 each
- `out0_badv`, `out1_badv`  out  32 each

## Operation
- Storage: DEPTH entries of {pc, inst, exception, badv}. `head` and `tail` pointers are log2(DEPTH) bits and wrap modulo DEPTH; `count` is 0..DEPTH.
- `in_ready = (count <= DEPTH-2)`, computed from the registered count only; a same-cycle pop does not raise it.
- Push occurs on `in_valid & in_ready & ~flush`. Entries written:
  - `in_exception != 0`: 1 entry {in_pc, 32'h0340_0000 (NOP), in_exception, in_badv}.
  - else if `in_pc[2]`: 1 entry {in_pc, in_inst1, 0, 0}.
  - else: 2 entries, {in_pc, in_inst0} at `tail`, then {in_pc+4, in_inst1} at `tail+1`.
- Presentation (combinational from `head`/`count`):
  - `out0_valid = (count >= 1)`.
  - `out1_valid = (count >= 2) & (entry[head].exception == 0)`. A faulting entry is always issued alone.
  - When a slot is invalid, it drives pc 32'h1c00_0000, inst NOP, exception 0, badv 0.
- Pop occurs on `out_ready & out0_valid & ~flush`. Popped = `out1_valid ? 2 : 1`, and `head` advances by that amount.
- Same-cycle push and pop: `count_next = count + pushed - popped`. Both pointers update independently.
- Flush has priority over push and pop: `head`, `tail`, and `count` go to 0 on the next edge, and entries are not cleared.
- Decode is never shown a partial packet out of order. Entries leave strictly in push order.

## Timing
- Reset (async assert): `head = tail = count = 0`. This gives `in_ready = 1`, `full = 0`, `out0_valid = out1_valid = 0`, and all out fields at their invalid-slot values. Storage contents are don't-care.
- Latency: an entry pushed at edge N is visible on `out0_*` after edge N. There is no same-cycle bypass when empty.
- Throughput: 2 in / 2 out per cycle sustained when `count` stays within 2..DEPTH-2.
- `in_ready` drops when `count >= DEPTH-1`, even if only a 1-entry push would fit. This guarantees no overflow.
- Wrap: a 2-entry push at `tail = DEPTH-1` writes slots DEPTH-1 and 0. A 2-entry pop at `head = DEPTH-1` reads slots DEPTH-1 and 0.
- Flush mid-operation: `in_valid` / `out_ready` in the flush cycle are ignored. The cycle after flush shows empty.
- Reset mid-operation: state clears immediately, regardless of `clk`.

## Test plan
- Reset, then push pc=0x1c000000 with inst 0xAAAA0000/0xBBBB0000 and `out_ready=0` → next cycle `count=2`, out0={0x1c000000,0xAAAA0000}, out1={0x1c000004,0xBBBB0000}, both valid.
- Push pc=0x1c000014 (pc[2]=1) with inst1=0xCCCC0000 into an empty buffer → `count=1`, out0={0x1c000014,0xCCCC0000}, `out1_valid=0`.
- Push exception 7'h08 with badv 0x1c000020, followed by a normal packet → out0 shows NOP with exc 0x08 and `out1_valid=0`. After one pop, the normal pair is presented.
- Fill with `out_ready=0` until `count=15` (DEPTH=16) → `in_ready=0`, `full=1`, and the held `in_valid` packet is not written. Pop 2 → `in_ready=1` the following cycle.
- Stream 20 packets with `out_ready=1` continuously, crossing the pointer wrap → every PC is output exactly once, in order. `count` stays ≤2.
- Flush asserted with `count=6`, a push and a pop in the same cycle → next cycle `count=0`, `out0_valid=0`, `in_ready=1`.
